// File: rtl/sha256_bwe_packer.sv
// SHA-256 message packer: streams bytes into a 16x32 byte-write-enable block buffer,
// appends 0x80 / zero fill / 64-bit length, and holds each full block until acknowledged.
module sha256_bwe_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_end,
    output logic        in_ready,
    output logic [3:0]  word_addr,
    output logic [3:0]  word_en,
    output logic [31:0] word_data,
    output logic        blk_full,
    output logic        blk_last,
    input  logic        blk_ack
);

    typedef enum logic [2:0] {
        S_DATA, S_PAD80, S_ZERO, S_LEN_HI, S_LEN_LO, S_BLK_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic [5:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [3:0]        en_q, en_d;
    logic [3:0]        addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              full_q, full_d;
    logic              blast_q, blast_d;

    logic              do_wr, wr_word;
    logic [7:0]        wr_byte;
    logic [31:0]       wr_val;
    logic [5:0]        ptr_inc1, ptr_inc4, ptr_zero_nxt;
    logic [1:0]        lane;
    logic [63:0]       bit_len;

    assign ptr_inc1 = ptr_q + 6'd1;
    assign ptr_inc4 = ptr_q + 6'd4;
    assign ptr_zero_nxt = (ptr_q[1:0] != 2'd0) ? ptr_inc1 : ptr_inc4;
    assign lane     = 2'd3 - ptr_q[1:0];
    assign bit_len  = {{(61-CNT_W){1'b0}}, cnt_q, 3'b000};
    assign in_ready = (state_q == S_DATA) && (cnt_q != CNT_MAX);

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        en_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        full_d  = full_q;
        blast_d = blast_q;
        do_wr   = 1'b0;
        wr_word = 1'b0;
        wr_byte = 8'h00;
        wr_val  = '0;

        unique case (state_q)
            S_DATA: begin
                if (in_valid && in_ready) begin
                    do_wr   = 1'b1;
                    wr_byte = in_byte;
                    cnt_d   = cnt_q + 1'b1;
                    ptr_d   = ptr_inc1;
                    // A simultaneous in_end that lands on the block's last byte resumes in PAD80.
                    if (ptr_q == 6'd63) begin
                        state_d = S_BLK_WAIT;
                        ret_d   = in_end ? S_PAD80 : S_DATA;
                    end else if (in_end) begin
                        state_d = S_PAD80;
                    end
                end else if (in_end) begin
                    state_d = S_PAD80;
                end
            end
            S_PAD80: begin
                do_wr   = 1'b1;
                wr_byte = 8'h80;
                ptr_d   = ptr_inc1;
                if (ptr_q == 6'd63) begin
                    state_d = S_BLK_WAIT;
                    ret_d   = S_ZERO;
                end else if (ptr_inc1 == 6'd56) begin
                    state_d = S_LEN_HI;
                end else begin
                    state_d = S_ZERO;
                end
            end
            S_ZERO: begin
                do_wr   = 1'b1;
                wr_word = (ptr_q[1:0] == 2'd0);
                ptr_d   = ptr_zero_nxt;
                if (ptr_zero_nxt == 6'd0) begin
                    state_d = S_BLK_WAIT;
                    ret_d   = S_ZERO;
                end else if (ptr_zero_nxt == 6'd56) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                do_wr   = 1'b1;
                wr_word = 1'b1;
                wr_val  = bit_len[63:32];
                ptr_d   = ptr_inc4;
                state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                do_wr   = 1'b1;
                wr_word = 1'b1;
                wr_val  = bit_len[31:0];
                ptr_d   = ptr_inc4;
                last_d  = 1'b1;
                state_d = S_BLK_WAIT;
            end
            S_BLK_WAIT: begin
                if (!full_q) begin
                    full_d  = 1'b1;
                    blast_d = last_q;
                end else if (blk_ack) begin
                    full_d  = 1'b0;
                    blast_d = 1'b0;
                    ptr_d   = '0;
                    if (last_q) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ret_q;
                    end
                end
            end
            default: state_d = S_DATA;
        endcase

        if (do_wr) begin
            addr_d = ptr_q[5:2];
            if (wr_word) begin
                en_d   = 4'b1111;
                data_d = wr_val;
            end else begin
                en_d   = 4'b0001 << lane;
                data_d = {24'h000000, wr_byte} << {lane, 3'b000};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= S_DATA;
            ret_q   <= S_DATA;
            ptr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            en_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            full_q  <= 1'b0;
            blast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            full_q  <= full_d;
            blast_q <= blast_d;
        end
    end

    assign word_en   = en_q;
    assign word_addr = addr_q;
    assign word_data = data_q;
    assign blk_full  = full_q;
    assign blk_last  = blast_q;

endmodule
